atmr_stim_voter: RTL and testbench
==================================

ATMR_STIM_VOTER -- requirements
Module: atmr_stim_voter

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, synchronous and active-high.
REQ-003 start  in  1  one-cycle run request; sampled only in IDLE.
REQ-004 seed  in  14  LFSR seed; latched on an accepted start.
REQ-005 num_vectors  in  16  number of vectors per run; latched on an accepted start.
REQ-006 vec_out  out  14  registered stimulus; bit k drives replica input i_k_.
REQ-007 resp_a, resp_b, resp_c  in  8 each  replica outputs; bit k = ori<k>.
REQ-008 voted  out  8  registered bitwise 2-of-3 majority of the last sampled responses.
REQ-009 busy  out  1  high in DRIVE and SAMPLE.
REQ-010 done  out  1  one-cycle pulse at end of run.
REQ-011 disagree_cnt  out  16  vectors where at least one replica word differs from voted.
REQ-012 fatal_cnt  out  16  vectors where no two replica words are equal.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE, FIN.
REQ-014 IDLE with start=1 and num_vectors!=0: latch seed (0x0000 replaced by 0x0001), load vec_out with it, clear both counters, go to DRIVE.
REQ-015 IDLE with start=1 and num_vectors=0: go to FIN, drive no vector, clear counters.
REQ-016 DRIVE: hold vec_out for one cycle to let the combinational replicas settle; go to SAMPLE.
REQ-017 SAMPLE: capture resp_a/b/c, update voted and counters, decrement the remaining count.
REQ-018 In SAMPLE, remaining count reaching 0 SHALL go to FIN; otherwise advance the LFSR and go to DRIVE.
REQ-019 LFSR step: fb = v[13]^v[12]^v[11]^v[1]; vec_out <= {v[12:0], fb}, a maximal-length sequence of period 16383.
REQ-020 FIN: done=1 for exactly one cycle, then IDLE; vec_out, voted and counters hold until the next accepted start.
REQ-021 Per-vector cost SHALL be 2 cycles; done SHALL assert 2*N+1 cycles after the cycle in which start is accepted.
REQ-022 voted[k] = (a[k]&b[k]) | (a[k]&c[k]) | (b[k]&c[k]).
REQ-023 disagree_cnt SHALL increment when a!=voted, b!=voted or c!=voted (word compare).
REQ-024 fatal_cnt SHALL increment when a!=b, a!=c and b!=c; such a vector also counts in disagree_cnt.
REQ-025 Both counters SHALL saturate at 0xFFFF without wrapping.
REQ-026 start while busy or in FIN SHALL be ignored; seed and num_vectors changes during a run SHALL have no effect.
REQ-027 num_vectors=0xFFFF SHALL run 65535 vectors; the LFSR SHALL wrap through its period without stalling.

Reset
REQ-028 rst=1 SHALL force IDLE, vec_out=0x0000, voted=0x00, both counters=0, busy=0, done=0 on the next edge.
REQ-029 rst SHALL override start and any state, including a run in progress; no done pulse is generated for an aborted run.
REQ-030 The first accepted start after rst release SHALL behave exactly as from power-up.

Verification
REQ-031 seed=0x0001, N=3, a=b=c=0xA5 -> vec_out 0x0001, 0x0002, 0x0005; voted=0xA5; disagree=0; fatal=0; done exactly 7 cycles after start.
REQ-032 N=4, a=b=0x3C, c=0xC3 -> voted=0x3C; disagree_cnt=4; fatal_cnt=0.
REQ-033 N=2, a=0x00, b=0x0F, c=0xF0 -> voted=0x00; disagree_cnt=2; fatal_cnt=2.
REQ-034 seed=0x0000, N=1 -> vec_out=0x0001 in DRIVE; N=0 -> done one cycle after start, counters 0, vec_out unchanged.
REQ-035 N=10, rst asserted at cycle 5 of the run -> next cycle IDLE with all outputs at reset values and no done pulse; a restart with N=1 completes normally.
REQ-036 Counters preset near 0xFFFF, then 3 more mismatching vectors -> disagree_cnt stays at 0xFFFF; a start pulse during busy has no effect.

Source files
------------

// File: rtl/atmr_stim_voter.sv
// Purpose: LFSR stimulus driver and 2-of-3 majority voter for a triplicated combinational block.
// Latency: 2 cycles per vector (drive, sample); done pulses 2*N+1 cycles after an accepted start.
// Backpressure: none; start is only honoured in IDLE, and is ignored while busy or in FIN.
module atmr_stim_voter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] seed,
    input  logic [15:0] num_vectors,
    output logic [13:0] vec_out,
    input  logic [7:0]  resp_a,
    input  logic [7:0]  resp_b,
    input  logic [7:0]  resp_c,
    output logic [7:0]  voted,
    output logic        busy,
    output logic        done,
    output logic [15:0] disagree_cnt,
    output logic [15:0] fatal_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] remaining;

    logic [7:0]  vote_now;
    logic        mismatch_now;
    logic        fatal_now;
    logic [13:0] lfsr_next;

    // Vote, classify the live replica responses, and compute the next LFSR word.
    always_comb begin
        vote_now     = (resp_a & resp_b) | (resp_a & resp_c) | (resp_b & resp_c);
        mismatch_now = (resp_a != vote_now) || (resp_b != vote_now) || (resp_c != vote_now);
        fatal_now    = (resp_a != resp_b) && (resp_a != resp_c) && (resp_b != resp_c);
        lfsr_next    = {vec_out[12:0], vec_out[13] ^ vec_out[12] ^ vec_out[11] ^ vec_out[1]};
    end

    // Run sequencer: all outputs are registered and only change on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= 16'd0;
            vec_out      <= 14'd0;
            voted        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            disagree_cnt <= 16'd0;
            fatal_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        disagree_cnt <= 16'd0;
                        fatal_cnt    <= 16'd0;
                        if (num_vectors != 16'd0) begin
                            // An all-zero seed would lock the LFSR, so it is nudged to 1.
                            vec_out   <= (seed == 14'd0) ? 14'd1 : seed;
                            remaining <= num_vectors;
                            busy      <= 1'b1;
                            state     <= DRIVE;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                DRIVE: begin
                    // Replicas are combinational; one full cycle lets them settle.
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    voted <= vote_now;
                    if (mismatch_now && (disagree_cnt != 16'hFFFF)) begin
                        disagree_cnt <= disagree_cnt + 16'd1;
                    end
                    if (fatal_now && (fatal_cnt != 16'hFFFF)) begin
                        fatal_cnt <= fatal_cnt + 16'd1;
                    end
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        vec_out <= lfsr_next;
                        state   <= DRIVE;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atmr_stim_voter.sv
// Purpose: self-checking bench for atmr_stim_voter using a vector table plus directed sequences.
// Latency: checks done timing of 2*N+1 cycles and per-cycle vec_out/busy/done behaviour.
// Backpressure: exercises start-while-busy and mid-run reset.
module tb_atmr_stim_voter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] seed;
    logic [15:0] num_vectors;
    logic [7:0]  resp_a;
    logic [7:0]  resp_b;
    logic [7:0]  resp_c;
    logic [13:0] vec_out;
    logic [7:0]  voted;
    logic        busy;
    logic        done;
    logic [15:0] disagree_cnt;
    logic [15:0] fatal_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    atmr_stim_voter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .num_vectors  (num_vectors),
        .vec_out      (vec_out),
        .resp_a       (resp_a),
        .resp_b       (resp_b),
        .resp_c       (resp_c),
        .voted        (voted),
        .busy         (busy),
        .done         (done),
        .disagree_cnt (disagree_cnt),
        .fatal_cnt    (fatal_cnt)
    );

    typedef struct {
        logic [13:0] seed;
        logic [15:0] n;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [7:0]  e_voted;
        logic [15:0] e_dis;
        logic [15:0] e_fat;
        logic [13:0] e_vec;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] lfsr_step(input logic [13:0] v);
        return {v[12:0], v[13] ^ v[12] ^ v[11] ^ v[1]};
    endfunction

    // Pulse start, check the first DRIVE cycle, then wait (bounded) for done.
    task automatic run(input logic [13:0] s, input logic [15:0] n, input int limit, output int lat);
        @(negedge clk);
        seed        = s;
        num_vectors = n;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        if (n != 16'd0) begin
            check("first_vec", 32'(vec_out), 32'((s == 14'd0) ? 14'd1 : s));
            check("busy_in_run", 32'(busy), 32'd1);
        end
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vec"},   32'(vec_out), 32'd0);
        check({tag, "_voted"}, 32'(voted), 32'd0);
        check({tag, "_dis"},   32'(disagree_cnt), 32'd0);
        check({tag, "_fat"},   32'(fatal_cnt), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [13:0] model_v;

        // seed, n, a, b, c, voted, disagree, fatal, final vec_out
        tbl[0] = '{14'h0001, 16'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 16'd0, 16'd0, 14'h0005};
        tbl[1] = '{14'h0001, 16'd4, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 16'd4, 16'd0, 14'h000A};
        tbl[2] = '{14'h0001, 16'd2, 8'h00, 8'h0F, 8'hF0, 8'h00, 16'd2, 16'd2, 14'h0002};
        tbl[3] = '{14'h0000, 16'd1, 8'hFF, 8'hFF, 8'h00, 8'hFF, 16'd1, 16'd0, 14'h0001};
        tbl[4] = '{14'h2000, 16'd2, 8'h12, 8'h34, 8'h56, 8'h16, 16'd2, 16'd2, 14'h0001};
        tbl[5] = '{14'h3FFF, 16'd2, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 16'd0, 16'd0, 14'h3FFE};
        // N=0: counters clear, vec_out and voted keep the previous run's values.
        tbl[6] = '{14'h1234, 16'd0, 8'h00, 8'hFF, 8'h0F, 8'h5A, 16'd0, 16'd0, 14'h3FFE};

        rst         = 1'b1;
        start       = 1'b1;
        seed        = 14'h0055;
        num_vectors = 16'd5;
        resp_a      = 8'h00;
        resp_b      = 8'h00;
        resp_c      = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        start = 1'b0;
        rst   = 1'b0;

        // Table-driven runs.
        for (int i = 0; i < 7; i++) begin
            resp_a = tbl[i].a;
            resp_b = tbl[i].b;
            resp_c = tbl[i].c;
            run(tbl[i].seed, tbl[i].n, 200, lat);
            check("latency",  32'(lat), 32'(2 * int'(tbl[i].n) + 1));
            check("done",     32'(done), 32'd1);
            check("busy_fin", 32'(busy), 32'd0);
            check("voted",    32'(voted), 32'(tbl[i].e_voted));
            check("disagree", 32'(disagree_cnt), 32'(tbl[i].e_dis));
            check("fatal",    32'(fatal_cnt), 32'(tbl[i].e_fat));
            check("vec_end",  32'(vec_out), 32'(tbl[i].e_vec));
            @(negedge clk);
            check("done_pulse", 32'(done), 32'd0);
        end

        // vec_out sequence per DRIVE cycle, exact done timing, start ignored while busy.
        resp_a = 8'hA5;
        resp_b = 8'hA5;
        resp_c = 8'hA5;
        @(negedge clk);
        seed        = 14'h0001;
        num_vectors = 16'd3;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 1) check("seq_vec1", 32'(vec_out), 32'h0001);
            if (c == 3) check("seq_vec2", 32'(vec_out), 32'h0002);
            if (c == 5) check("seq_vec3", 32'(vec_out), 32'h0005);
            check("seq_done", 32'(done), 32'(c == 7));
            check("seq_busy", 32'(busy), 32'(c != 7));
            if (c == 3) begin
                seed        = 14'h0100;
                num_vectors = 16'd9;
                start       = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c < 7) @(negedge clk);
        end
        @(negedge clk);
        check("seq_done_low", 32'(done), 32'd0);
        check("seq_vec_hold", 32'(vec_out), 32'h0005);

        // Reset in the middle of a run aborts it without a done pulse.
        resp_a = 8'h3C;
        resp_b = 8'h3C;
        resp_c = 8'hC3;
        @(negedge clk);
        seed        = 14'h0001;
        num_vectors = 16'd10;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("abort");
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run(14'h0007, 16'd1, 50, lat);
        check("restart_latency", 32'(lat), 32'd3);
        check("restart_dis",     32'(disagree_cnt), 32'd1);
        check("restart_vec",     32'(vec_out), 32'h0007);
        check("restart_voted",   32'(voted), 32'h3C);

        // Counter saturation: preset both counters to 0xFFFE across the first SAMPLE edge.
        resp_a = 8'h00;
        resp_b = 8'h0F;
        resp_c = 8'hF0;
        @(negedge clk);
        seed        = 14'h0001;
        num_vectors = 16'd3;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        force dut.disagree_cnt = 16'hFFFE;
        force dut.fatal_cnt    = 16'hFFFE;
        @(negedge clk);
        release dut.disagree_cnt;
        release dut.fatal_cnt;
        seed        = 14'h2000;
        num_vectors = 16'd1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("sat_latency", 32'(lat), 32'd7);
        check("sat_dis",     32'(disagree_cnt), 32'hFFFF);
        check("sat_fat",     32'(fatal_cnt), 32'hFFFF);
        check("sat_vec",     32'(vec_out), 32'h0005);

        // Longer run: final vector against the LFSR recurrence.
        resp_a = 8'h77;
        resp_b = 8'h77;
        resp_c = 8'h77;
        model_v = 14'h1ACE;
        for (int k = 1; k < 1000; k++) model_v = lfsr_step(model_v);
        run(14'h1ACE, 16'd1000, 2100, lat);
        check("long_latency", 32'(lat), 32'd2001);
        check("long_vec",     32'(vec_out), 32'(model_v));
        check("long_dis",     32'(disagree_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
